spi_peripheral: RTL and testbench
=================================

# spi_peripheral

Mode-0 SPI responder (CPOL=0, CPHA=0, MSB first) that is the far end of the team's SPI controller. It oversamples SCK, COPI and CS_n on CLOCK_50 and delivers each received byte as a one-cycle strobe. It shifts out a byte buffered by local logic, or FILL_BYTE on underrun. It sits between the board SPI pins and a local register or command interface.

## Interface

Parameters:
- FILL_BYTE, 8'hFF, byte transmitted when no byte is buffered at byte start.
- SYNC_STAGES, 2, synchronizer depth on SCK, COPI and CS_n; legal values are 2 and 3.

Ports:
- CLOCK_50  input  1  system clock; the single clock of the block.
- reset  input  1  asynchronous, active-high reset.
- SCK  input  1  SPI clock from the controller; asynchronous to CLOCK_50.
- COPI  input  1  controller-out data.
- CS_n  input  1  active-low select; tie to 0 for unframed, counter-only operation.
- CIPO  output  1  peripheral-out data.
- tx_byte  input  8  next byte to transmit.
- tx_load  input  1  one-cycle write of tx_byte into the holding buffer.
- tx_ready  output  1  high when the holding buffer is empty.
- rx_byte  output  8  last complete received byte; holds until the next completion.
- rx_valid  output  1  one-cycle strobe when rx_byte updates.
- tx_underrun  output  1  one-cycle strobe when FILL_BYTE is substituted.
- busy  output  1  high while CS_n is synchronized low and a byte is in progress.

## Operation

- Synchronized inputs are sck_s, copi_s and cs_s (active-high select).
- Edge detect uses the last two sck_s samples to produce sck_rise and sck_fall.
- cs_s has its own rising and falling detect.
- States:
  - IDLE: cs_s=0, CIPO=1, bit_count=0.
  - SHIFT: cs_s=1, bytes are being shifted.
- IDLE->SHIFT on cs_s rising:
  - Load the tx shift register from the buffer if full (clear buffer), else from FILL_BYTE (pulse tx_underrun).
  - Drive CIPO = shift[7] the same cycle.
- In SHIFT:
  - On sck_rise: rx_shift <= {rx_shift[6:0], copi_s}, bit_count += 1 (3-bit counter, wraps 7->0).
  - On sck_rise with bit_count==7: rx_byte <= {rx_shift[6:0], copi_s} and rx_valid=1 next cycle.
  - On sck_fall, bit_count!=0: tx shift left by one; CIPO = new shift[7].
  - On sck_fall, bit_count==0 and at least one byte completed: reload the tx shift from buffer/FILL_BYTE as on entry; CIPO = new MSB.
- SHIFT->IDLE on cs_s falling:
  - Discard partial rx bits; no rx_valid.
  - bit_count <= 0, CIPO <= 1.
  - A byte still held in the holding buffer is retained.
- Holding buffer (1 entry):
  - tx_load writes tx_byte and sets full.
  - tx_load while full overwrites the buffered byte.
  - tx_load in the same cycle as consumption: the new byte is stored and the buffer stays full; the consumed byte is the old one.
  - tx_ready = ~full.
- busy = cs_s && (bit_count!=0 || sck_s==1).
- Async reset sets:
  - state=IDLE, CIPO=1, rx_byte=0, rx_valid=0, tx_underrun=0, tx_ready=1, busy=0.
  - All shift registers and synchronizer flops to 0.
  - Synchronizers for CS_n reset to 1 (deselected).
- Reset mid-byte aborts with no strobe. After reset release, a CS_n already low is not a cs_s rising edge.
- Ignore sck edges in IDLE.

## Timing

- Input-to-action latency: SYNC_STAGES + 1 CLOCK_50 cycles from a pin edge.
- SCK high and low times must each be at least SYNC_STAGES+2 CLOCK_50 cycles. The CIPO update must reach the pin before the controller's next rising sample.
- CS_n falling to first SCK rising must be at least SYNC_STAGES+2 cycles.
- rx_valid is asserted exactly 1 cycle after the internal sck_rise of bit 8; rx_byte is valid in the same cycle as rx_valid.
- A byte loaded with tx_load at least 1 cycle before the reload event is the byte transmitted.
- Throughput is back-to-back bytes with no gap cycles on SCK.

## Structure

- Shared spi_pkg holds:
  - state enum (IDLE, SHIFT);
  - SPI_MODE0 constants;
  - default FILL_BYTE 8'hFF.
- Sub-module spi_input_sync:
  - parameterized depth, reset value per instance;
  - three instances (SCK, COPI and CS_n).
- Edge detect, FSM, shifters and buffer live in spi_peripheral.

## Test plan

- Reset with tx_load=0, then CS_n low and controller sends 8'hA5 -> rx_valid once with rx_byte=8'hA5. CIPO shifts 8'hFF; tx_underrun pulses once at CS_n low.
- tx_load 8'h3C, then CS_n low and controller sends 8'h5A -> controller receives 8'h3C, rx_byte=8'h5A. tx_ready is 0 after the load and 1 after the CS_n edge.
- Three back-to-back bytes 8'h01, 8'h80, 8'hFF with tx_load of 8'h11, 8'h22 issued during bytes 1–2:
  - three rx_valid strobes with the matching rx_byte values;
  - CIPO carries 8'h11, 8'h22, FILL_BYTE.
- CS_n raised after 5 SCK rising edges -> no rx_valid; busy=0. The next framed byte 8'hC3 is received exactly.
- tx_load in the same cycle as the consumption point -> the old byte is sent, the new byte is retained, and tx_ready stays 0.
- Assert reset mid-byte after 4 bits -> all outputs return to reset values within the same cycle; no rx_valid. A following byte 8'h96 is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI peripheral: FSM state encoding, SPI mode-0
// constants and the default underrun fill byte.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam logic [7:0] DEFAULT_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin; the reset level is
// chosen per instance so each pin wakes up in its idle state.
module spi_input_sync #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {DEPTH{RST_VAL}};
    else     sync_q <= {sync_q[DEPTH-2:0], d_i};
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/spi_peripheral.sv
// Mode-0 SPI responder: oversamples SCK/COPI/CS_n on CLOCK_50, strobes out
// received bytes and shifts out a one-entry buffered byte or FILL_BYTE.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter logic [7:0] FILL_BYTE   = DEFAULT_FILL_BYTE,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       SCK,
  input  logic       COPI,
  input  logic       CS_n,
  output logic       CIPO,
  input  logic [7:0] tx_byte,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       busy
);

  localparam logic [2:0] SETTLE_DONE = 3'(SYNC_STAGES + 1);

  logic sck_s, copi_s, cs_n_s, cs_s;

  spi_input_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sync_sck (
    .clk(CLOCK_50), .rst(reset), .d_i(SCK), .q_o(sck_s));
  spi_input_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(CLOCK_50), .rst(reset), .d_i(COPI), .q_o(copi_s));
  spi_input_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .clk(CLOCK_50), .rst(reset), .d_i(CS_n), .q_o(cs_n_s));

  assign cs_s = ~cs_n_s;

  state_e     state_q,       state_d;
  logic       sck_q,         cs_q;
  logic [2:0] settle_q,      settle_d;
  logic [2:0] bit_cnt_q,     bit_cnt_d;
  logic [6:0] rx_shift_q,    rx_shift_d;
  logic [7:0] rx_byte_q,     rx_byte_d;
  logic       rx_valid_q,    rx_valid_d;
  logic [7:0] tx_shift_q,    tx_shift_d;
  logic [7:0] buf_q,         buf_d;
  logic       buf_full_q,    buf_full_d;
  logic       underrun_q,    underrun_d;
  logic       byte_done_q,   byte_done_d;

  logic settled, cs_rise, sck_rise, sck_fall, consume;

  // A select already active when reset releases must not look like a new frame,
  // so select edges count only once the CS_n synchronizer and cs_q have refilled.
  assign settled  = (settle_q == SETTLE_DONE);
  assign cs_rise  = settled & cs_s & ~cs_q;
  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;

  always_comb begin
    // NOTE: every next-state signal gets a default here so no path infers a latch.
    state_d     = state_q;
    settle_d    = settled ? settle_q : settle_q + 3'd1;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    tx_shift_d  = tx_shift_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    underrun_d  = 1'b0;
    byte_done_d = byte_done_q;
    consume     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_s && settled) begin
          state_d     = SHIFT;
          bit_cnt_d   = 3'd0;
          byte_done_d = 1'b0;
          consume     = cs_rise;
        end
      end
      SHIFT: begin
        if (!cs_s) begin
          state_d     = IDLE;
          bit_cnt_d   = 3'd0;
          rx_shift_d  = 7'd0;
          byte_done_d = 1'b0;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[5:0], copi_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_byte_d   = {rx_shift_q, copi_s};
            rx_valid_d  = 1'b1;
            byte_done_d = 1'b1;
          end
        end else if (sck_fall) begin
          if (bit_cnt_q != 3'd0) tx_shift_d = {tx_shift_q[6:0], 1'b0};
          else if (byte_done_q)  consume    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (consume) begin
      tx_shift_d = buf_full_q ? buf_q : FILL_BYTE;
      underrun_d = ~buf_full_q;
      buf_full_d = 1'b0;
    end

    // A load in the consumption cycle wins: the old byte goes out, the new one stays.
    if (tx_load) begin
      buf_d      = tx_byte;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      sck_q       <= SPI_CPOL;
      cs_q        <= 1'b0;
      settle_q    <= 3'd0;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 7'd0;
      rx_byte_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      tx_shift_q  <= 8'd0;
      buf_q       <= 8'd0;
      buf_full_q  <= 1'b0;
      underrun_q  <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_q       <= sck_s;
      cs_q        <= cs_s;
      settle_q    <= settle_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      tx_shift_q  <= tx_shift_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      underrun_q  <= underrun_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign CIPO        = (state_q == SHIFT) ? tx_shift_q[7] : 1'b1;
  assign tx_ready    = ~buf_full_q;
  assign rx_byte     = rx_byte_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign busy        = cs_s & ((bit_cnt_q != 3'd0) | sck_s);

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a behavioural mode-0 controller drives the
// pins while monitors log rx_valid strobes and tx_underrun pulses.
module tb_spi_peripheral;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       SCK, COPI, CS_n, CIPO;
  logic [7:0] tx_byte;
  logic       tx_load, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0] rx_byte;

  spi_peripheral #(.FILL_BYTE(8'hFF), .SYNC_STAGES(2)) dut (
    .CLOCK_50(clk), .reset(reset), .SCK(SCK), .COPI(COPI), .CS_n(CS_n),
    .CIPO(CIPO), .tx_byte(tx_byte), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .busy(busy));

  always #10 clk = ~clk;

  int         n_total = 0;
  int         n_pass  = 0;
  int         rx_cnt  = 0;
  int         urun_cnt = 0;
  logic [7:0] rx_log[$];

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_cnt++;
      rx_log.push_back(rx_byte);
    end
    if (tx_underrun === 1'b1) urun_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each bit: drop SCK, present COPI, sample CIPO, raise SCK. Ends with SCK high.
  task automatic spi_bits(input logic [7:0] mosi, input int nbits, input int load_bit,
                          input logic [7:0] load_val, output logic [7:0] miso);
    miso = 8'd0;
    for (int i = 0; i < nbits; i++) begin
      SCK  = 1'b0;
      COPI = mosi[7-i];
      if (i == load_bit) begin
        tx_byte = load_val;
        tx_load = 1'b1;
        cyc(1);
        tx_load = 1'b0;
        cyc(HALF - 1);
      end else begin
        cyc(HALF);
      end
      miso = {miso[6:0], CIPO};
      SCK  = 1'b1;
      cyc(HALF);
    end
  endtask

  task automatic frame_start();
    CS_n = 1'b0;
    cyc(HALF);
  endtask

  task automatic frame_end();
    CS_n = 1'b1;
    SCK  = 1'b0;
    cyc(HALF);
  endtask

  task automatic load(input logic [7:0] val);
    tx_byte = val;
    tx_load = 1'b1;
    cyc(1);
    tx_load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cipo"},     CIPO,        1'b1);
    check({pfx, "_rx_byte"},  rx_byte,     8'h00);
    check({pfx, "_rx_valid"}, rx_valid,    1'b0);
    check({pfx, "_underrun"}, tx_underrun, 1'b0);
    check({pfx, "_tx_ready"}, tx_ready,    1'b1);
    check({pfx, "_busy"},     busy,        1'b0);
  endtask

  initial begin
    logic [7:0] miso;
    int rx0, ur0;

    reset = 1'b1; SCK = 1'b0; COPI = 1'b0; CS_n = 1'b1;
    tx_byte = 8'h00; tx_load = 1'b0;
    cyc(3);
    check_reset_outputs("rst");
    reset = 1'b0;
    cyc(4);

    // Underrun frame: controller sends A5, peripheral answers FILL_BYTE.
    rx0 = rx_cnt; ur0 = urun_cnt; rx_log.delete();
    frame_start();
    spi_bits(8'hA5, 8, -1, 8'h00, miso);
    frame_end();
    check("t1_miso",     miso,            8'hFF);
    check("t1_rx_cnt",   rx_cnt - rx0,    1);
    check("t1_rx_byte",  rx_byte,         8'hA5);
    check("t1_underrun", urun_cnt - ur0,  1);

    // Buffered byte is sent and the buffer empties at the select edge.
    rx0 = rx_cnt; ur0 = urun_cnt;
    load(8'h3C);
    check("t2_ready_after_load", tx_ready, 1'b0);
    frame_start();
    check("t2_ready_after_cs", tx_ready, 1'b1);
    spi_bits(8'h5A, 8, -1, 8'h00, miso);
    frame_end();
    check("t2_miso",    miso,          8'h3C);
    check("t2_rx_byte", rx_byte,       8'h5A);
    check("t2_rx_cnt",  rx_cnt - rx0,  1);

    // Back-to-back bytes: 11 buffered at frame start, 22 loaded mid byte 1.
    ur0 = urun_cnt; rx_log.delete();
    load(8'h11);
    frame_start();
    spi_bits(8'h01, 8, 3, 8'h22, miso);
    check("t3_miso0", miso, 8'h11);
    spi_bits(8'h80, 8, -1, 8'h00, miso);
    check("t3_miso1", miso, 8'h22);
    spi_bits(8'hFF, 8, -1, 8'h00, miso);
    check("t3_miso2", miso, 8'hFF);
    frame_end();
    check("t3_rx_cnt",  rx_log.size(), 3);
    if (rx_log.size() == 3) begin
      check("t3_rx0", rx_log[0], 8'h01);
      check("t3_rx1", rx_log[1], 8'h80);
      check("t3_rx2", rx_log[2], 8'hFF);
    end
    check("t3_underrun", urun_cnt - ur0, 1);

    // Aborted partial byte, then a clean framed byte.
    rx0 = rx_cnt;
    frame_start();
    spi_bits(8'hE7, 5, -1, 8'h00, miso);
    frame_end();
    check("t4_no_rx",    rx_cnt - rx0, 0);
    check("t4_busy",     busy,         1'b0);
    check("t4_rx_hold",  rx_byte,      8'hFF);
    frame_start();
    spi_bits(8'hC3, 8, -1, 8'h00, miso);
    frame_end();
    check("t4_rx_byte",  rx_byte,      8'hC3);

    // Load lands in the exact consumption cycle (two cycles after CS_n falls).
    load(8'h44);
    CS_n = 1'b0;
    cyc(2);
    tx_byte = 8'h55;
    tx_load = 1'b1;
    cyc(1);
    tx_load = 1'b0;
    cyc(HALF - 3);
    check("t5_ready", tx_ready, 1'b0);
    spi_bits(8'h00, 8, -1, 8'h00, miso);
    frame_end();
    check("t5_old_sent", miso, 8'h44);
    frame_start();
    spi_bits(8'h00, 8, -1, 8'h00, miso);
    frame_end();
    check("t5_new_sent", miso, 8'h55);

    // Reset in the middle of a byte.
    rx0 = rx_cnt;
    frame_start();
    spi_bits(8'h69, 4, -1, 8'h00, miso);
    reset = 1'b1;
    #1;
    check_reset_outputs("t6");
    CS_n = 1'b1;
    SCK  = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(4);
    check("t6_no_rx", rx_cnt - rx0, 0);
    frame_start();
    spi_bits(8'h96, 8, -1, 8'h00, miso);
    frame_end();
    check("t6_rx_byte", rx_byte, 8'h96);
    check("t6_rx_cnt",  rx_cnt - rx0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
